// File: rtl/sprite_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_draw_arbiter
// Description : Fixed-priority arbiter sharing one VGA pixel-write port among
//               four sprite requesters; scans a sprite from ROM and plots it
//               with transparency and screen clipping.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_draw_arbiter #(
    parameter int                 X_SCREEN_PIXELS = 160,
    parameter int                 Y_SCREEN_PIXELS = 120,
    parameter int                 SPR_W           = 16,
    parameter int                 SPR_H           = 16,
    parameter int                 COLOUR_W        = 3,
    parameter logic [COLOUR_W-1:0] TRANSPARENT    = 3'b101
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [11:0]         req_sprite,
    input  logic [31:0]         req_x,
    input  logic [27:0]         req_y,
    output logic [3:0]          grant,
    output logic [3:0]          done,
    output logic                busy,
    output logic [10:0]         rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int c_COL_W = $clog2(SPR_W);
    localparam int c_ROW_W = $clog2(SPR_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(SPR_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(SPR_H - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_FLUSH1 = 3'd2;
    localparam logic [2:0] S_FLUSH2 = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;

    logic [1:0]          r_idx;
    logic [2:0]          r_sprite;
    logic [7:0]          r_x0;
    logic [6:0]          r_y0;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;

    logic                r_p1_valid;
    logic [c_COL_W-1:0]  r_p1_col;
    logic [c_ROW_W-1:0]  r_p1_row;

    logic [7:0]          r_vga_x;
    logic [6:0]          r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;
    logic                r_vga_plot;

    logic [1:0]          w_sel_idx;
    logic [2:0]          w_sel_sprite;
    logic [7:0]          w_sel_x;
    logic [6:0]          w_sel_y;
    logic                w_scan_last;
    logic [8:0]          w_x_sum;
    logic [7:0]          w_y_sum;
    logic                w_on_screen;
    logic [3:0]          w_onehot;

    // Lowest set index wins: scan from the top so bit 0 overrides.
    always_comb begin
        w_sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                w_sel_idx = 2'(i);
            end
        end
    end

    always_comb begin
        w_sel_sprite = 3'd0;
        w_sel_x      = 8'd0;
        w_sel_y      = 7'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_sel_idx == 2'(i)) begin
                w_sel_sprite = req_sprite[3*i +: 3];
                w_sel_x      = req_x[8*i +: 8];
                w_sel_y      = req_y[7*i +: 7];
            end
        end
    end

    assign w_scan_last = (r_state == S_SCAN) && (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (req != 4'd0) w_next_state = S_SCAN;
            S_SCAN:   if (w_scan_last) w_next_state = S_FLUSH1;
            S_FLUSH1: w_next_state = S_FLUSH2;
            S_FLUSH2: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Requester context is captured only in IDLE, so later req changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= 2'd0;
            r_sprite <= 3'd0;
            r_x0     <= 8'd0;
            r_y0     <= 7'd0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (r_state == S_IDLE) begin
            r_col <= '0;
            r_row <= '0;
            if (req != 4'd0) begin
                r_idx    <= w_sel_idx;
                r_sprite <= w_sel_sprite;
                r_x0     <= w_sel_x;
                r_y0     <= w_sel_y;
            end
        end else if (r_state == S_SCAN) begin
            r_col <= r_col + 1'b1;
            if (r_col == c_COL_LAST) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    // Stage 1 tracks the coordinate whose texel arrives from the ROM next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_valid <= 1'b0;
            r_p1_col   <= '0;
            r_p1_row   <= '0;
        end else begin
            r_p1_valid <= (r_state == S_SCAN);
            r_p1_col   <= r_col;
            r_p1_row   <= r_row;
        end
    end

    assign w_x_sum     = {1'b0, r_x0} + 9'(r_p1_col);
    assign w_y_sum     = {1'b0, r_y0} + 8'(r_p1_row);
    assign w_on_screen = (w_x_sum < 9'(X_SCREEN_PIXELS)) && (w_y_sum < 8'(Y_SCREEN_PIXELS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_x      <= w_x_sum[7:0];
            r_vga_y      <= w_y_sum[6:0];
            r_vga_colour <= rom_data;
            r_vga_plot   <= r_p1_valid && (rom_data != TRANSPARENT) && w_on_screen;
        end
    end

    assign w_onehot   = 4'b0001 << r_idx;
    assign grant      = ((r_state == S_SCAN) || (r_state == S_FLUSH1) || (r_state == S_FLUSH2))
                        ? w_onehot : 4'd0;
    assign done       = (r_state == S_DONE) ? w_onehot : 4'd0;
    assign busy       = (r_state != S_IDLE);
    assign rom_addr   = (r_state == S_SCAN)
                        ? 11'(r_sprite) * 11'(SPR_W * SPR_H) + 11'(r_row) * 11'(SPR_W) + 11'(r_col)
                        : 11'd0;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule
`default_nettype wire

// File: tb/tb_sprite_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_draw_arbiter
// Description : Directed self-checking bench for sprite_draw_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_draw_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] req_sprite;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [10:0] rom_addr;
    logic [2:0]  rom_data = 3'd0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int tests = 0;
    int fails = 0;

    int rom_mode = 0;
    int mon_x0   = 0;
    int mon_y0   = 0;
    int plot_cnt = 0;
    int bad_cnt  = 0;
    int ovl_cnt  = 0;
    int done_cnt = 0;
    int m_col;
    int m_row;
    logic [2:0] m_exp;

    sprite_draw_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_sprite (req_sprite),
        .req_x      (req_x),
        .req_y      (req_y),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    // Mode 0: colour = col[1:0]; mode 1: odd cols transparent, else colour = row[1:0].
    always @(posedge clk) begin
        if (rom_mode == 1 && rom_addr[0]) rom_data <= 3'b101;
        else if (rom_mode == 1)           rom_data <= {1'b0, rom_addr[5:4]};
        else                              rom_data <= {1'b0, rom_addr[1:0]};
    end

    always @(negedge clk) begin
        if (grant != 4'd0 && done != 4'd0) ovl_cnt++;
        if (done != 4'd0) done_cnt++;
        if (vga_plot) begin
            plot_cnt++;
            m_col = int'(vga_x) - mon_x0;
            m_row = int'(vga_y) - mon_y0;
            if (vga_x >= 8'd160 || vga_y >= 7'd120 || m_col < 0 || m_col > 15 || m_row < 0 || m_row > 15) begin
                bad_cnt++;
            end else begin
                m_exp = (rom_mode == 1) ? {1'b0, m_row[1:0]} : {1'b0, m_col[1:0]};
                if (rom_mode == 1 && m_col[0]) bad_cnt++;
                if (vga_colour !== m_exp) bad_cnt++;
            end
            if (!busy || done != 4'd0) bad_cnt++;
        end
    end

    task automatic set_field(input int idx, input logic [2:0] spr, input logic [7:0] x, input logic [6:0] y);
        req_sprite[3*idx +: 3] = spr;
        req_x[8*idx +: 8]      = x;
        req_y[7*idx +: 7]      = y;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req = 4'd0; req_sprite = 12'd0; req_x = 32'd0; req_y = 28'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (grant !== 4'd0)    begin fails++; $display("FAIL reset_grant got %b want 0000", grant); end
        tests++; if (done !== 4'd0)     begin fails++; $display("FAIL reset_done got %b want 0000", done); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (vga_plot !== 1'b0) begin fails++; $display("FAIL reset_plot got %b want 0", vga_plot); end
        tests++; if (rom_addr !== 11'd0) begin fails++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        tests++; if (vga_x !== 8'd0)    begin fails++; $display("FAIL reset_vga_x got %0d want 0", vga_x); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int p0, b0;
        rom_mode = 0; mon_x0 = 10; mon_y0 = 20;
        set_field(2, 3'd3, 8'd10, 7'd20);
        p0 = plot_cnt; b0 = bad_cnt;
        req = 4'b0100;
        @(posedge clk); @(negedge clk);
        tests++; if (grant !== 4'b0100)   begin fails++; $display("FAIL single_grant got %b want 0100", grant); end
        tests++; if (rom_addr !== 11'd768) begin fails++; $display("FAIL single_addr_first got %0d want 768", rom_addr); end
        tests++; if (busy !== 1'b1)       begin fails++; $display("FAIL single_busy got %b want 1", busy); end
        req = 4'd0;
        repeat (2) @(negedge clk);
        tests++; if (vga_plot !== 1'b1 || vga_x !== 8'd10 || vga_y !== 7'd20)
            begin fails++; $display("FAIL single_first_plot got plot=%b (%0d,%0d) want 1 (10,20)", vga_plot, vga_x, vga_y); end
        repeat (253) @(negedge clk);
        tests++; if (rom_addr !== 11'd1023) begin fails++; $display("FAIL single_addr_last got %0d want 1023", rom_addr); end
        repeat (2) @(negedge clk);
        tests++; if (vga_plot !== 1'b1 || vga_x !== 8'd25 || vga_y !== 7'd35)
            begin fails++; $display("FAIL single_last_plot got plot=%b (%0d,%0d) want 1 (25,35)", vga_plot, vga_x, vga_y); end
        @(negedge clk);
        tests++; if (done !== 4'b0100 || grant !== 4'd0)
            begin fails++; $display("FAIL single_done got done=%b grant=%b want 0100 0000", done, grant); end
        @(negedge clk);
        tests++; if (done !== 4'd0 || busy !== 1'b0)
            begin fails++; $display("FAIL single_idle got done=%b busy=%b want 0000 0", done, busy); end
        tests++; if (plot_cnt - p0 !== 256) begin fails++; $display("FAIL single_plot_count got %0d want 256", plot_cnt - p0); end
        tests++; if (bad_cnt - b0 !== 0)    begin fails++; $display("FAIL single_bad_pixels got %0d want 0", bad_cnt - b0); end
    endtask

    task automatic test_simultaneous;
        int p0, b0, o0;
        rom_mode = 0; mon_x0 = 5; mon_y0 = 5;
        set_field(1, 3'd1, 8'd5, 7'd5);
        set_field(3, 3'd2, 8'd60, 7'd60);
        p0 = plot_cnt; b0 = bad_cnt; o0 = ovl_cnt;
        req = 4'b1010;
        @(posedge clk); @(negedge clk);
        tests++; if (grant !== 4'b0010)   begin fails++; $display("FAIL simul_first_grant got %b want 0010", grant); end
        tests++; if (rom_addr !== 11'd256) begin fails++; $display("FAIL simul_first_addr got %0d want 256", rom_addr); end
        req = 4'b1000;
        repeat (258) @(negedge clk);
        tests++; if (done !== 4'b0010) begin fails++; $display("FAIL simul_first_done got %b want 0010", done); end
        mon_x0 = 60; mon_y0 = 60;
        @(negedge clk);
        tests++; if (grant !== 4'd0) begin fails++; $display("FAIL simul_gap_grant got %b want 0000", grant); end
        @(negedge clk);
        tests++; if (grant !== 4'b1000)   begin fails++; $display("FAIL simul_second_grant got %b want 1000", grant); end
        tests++; if (rom_addr !== 11'd512) begin fails++; $display("FAIL simul_second_addr got %0d want 512", rom_addr); end
        req = 4'd0;
        repeat (258) @(negedge clk);
        tests++; if (done !== 4'b1000) begin fails++; $display("FAIL simul_second_done got %b want 1000", done); end
        @(negedge clk);
        tests++; if (ovl_cnt - o0 !== 0)    begin fails++; $display("FAIL simul_overlap got %0d want 0", ovl_cnt - o0); end
        tests++; if (plot_cnt - p0 !== 512) begin fails++; $display("FAIL simul_plot_count got %0d want 512", plot_cnt - p0); end
        tests++; if (bad_cnt - b0 !== 0)    begin fails++; $display("FAIL simul_bad_pixels got %0d want 0", bad_cnt - b0); end
    endtask

    task automatic test_clip;
        int p0, b0;
        rom_mode = 0; mon_x0 = 150; mon_y0 = 110;
        set_field(0, 3'd0, 8'd150, 7'd110);
        p0 = plot_cnt; b0 = bad_cnt;
        req = 4'b0001;
        @(posedge clk); @(negedge clk);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL clip_grant got %b want 0001", grant); end
        req = 4'd0;
        repeat (258) @(negedge clk);
        tests++; if (done !== 4'b0001) begin fails++; $display("FAIL clip_done got %b want 0001", done); end
        @(negedge clk);
        tests++; if (plot_cnt - p0 !== 100) begin fails++; $display("FAIL clip_plot_count got %0d want 100", plot_cnt - p0); end
        tests++; if (bad_cnt - b0 !== 0)    begin fails++; $display("FAIL clip_bad_pixels got %0d want 0", bad_cnt - b0); end
    endtask

    task automatic test_transparency;
        int p0, b0;
        rom_mode = 1; mon_x0 = 40; mon_y0 = 50;
        set_field(3, 3'd5, 8'd40, 7'd50);
        p0 = plot_cnt; b0 = bad_cnt;
        req = 4'b1000;
        @(posedge clk); @(negedge clk);
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL transp_grant got %b want 1000", grant); end
        req = 4'd0;
        repeat (258) @(negedge clk);
        tests++; if (done !== 4'b1000) begin fails++; $display("FAIL transp_done got %b want 1000", done); end
        @(negedge clk);
        tests++; if (plot_cnt - p0 !== 128) begin fails++; $display("FAIL transp_plot_count got %0d want 128", plot_cnt - p0); end
        tests++; if (bad_cnt - b0 !== 0)    begin fails++; $display("FAIL transp_bad_pixels got %0d want 0", bad_cnt - b0); end
        rom_mode = 0;
    endtask

    task automatic test_reset_mid_scan;
        int p0, d0;
        rom_mode = 0; mon_x0 = 0; mon_y0 = 0;
        set_field(0, 3'd1, 8'd0, 7'd0);
        req = 4'b0001;
        @(posedge clk); @(negedge clk);
        req = 4'd0;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (grant !== 4'd0 || vga_plot !== 1'b0 || busy !== 1'b0)
            begin fails++; $display("FAIL midreset_state got grant=%b plot=%b busy=%b want 0000 0 0", grant, vga_plot, busy); end
        reset = 1'b0;
        p0 = plot_cnt; d0 = done_cnt;
        repeat (300) @(negedge clk);
        tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL midreset_no_done got %0d want 0", done_cnt - d0); end
        tests++; if (plot_cnt - p0 !== 0) begin fails++; $display("FAIL midreset_no_plot got %0d want 0", plot_cnt - p0); end
        mon_x0 = 30; mon_y0 = 30;
        set_field(2, 3'd0, 8'd30, 7'd30);
        req = 4'b0100;
        @(posedge clk); @(negedge clk);
        tests++; if (grant !== 4'b0100)  begin fails++; $display("FAIL midreset_regrant got %b want 0100", grant); end
        tests++; if (rom_addr !== 11'd0) begin fails++; $display("FAIL midreset_regrant_addr got %0d want 0", rom_addr); end
        req = 4'd0;
        repeat (258) @(negedge clk);
        tests++; if (done !== 4'b0100) begin fails++; $display("FAIL midreset_redone got %b want 0100", done); end
        @(negedge clk);
    endtask

    task automatic test_req_drop;
        int p0, b0;
        rom_mode = 0; mon_x0 = 70; mon_y0 = 80;
        set_field(1, 3'd7, 8'd70, 7'd80);
        p0 = plot_cnt; b0 = bad_cnt;
        req = 4'b0010;
        @(posedge clk); @(negedge clk);
        tests++; if (rom_addr !== 11'd1792) begin fails++; $display("FAIL drop_addr got %0d want 1792", rom_addr); end
        repeat (5) @(negedge clk);
        req = 4'd0;
        repeat (253) @(negedge clk);
        tests++; if (done !== 4'b0010) begin fails++; $display("FAIL drop_done got %b want 0010", done); end
        @(negedge clk);
        tests++; if (plot_cnt - p0 !== 256) begin fails++; $display("FAIL drop_plot_count got %0d want 256", plot_cnt - p0); end
        tests++; if (bad_cnt - b0 !== 0)    begin fails++; $display("FAIL drop_bad_pixels got %0d want 0", bad_cnt - b0); end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'd0;
        @(negedge clk);
        test_reset;
        test_single;
        test_simultaneous;
        test_clip;
        test_transparency;
        test_reset_mid_scan;
        test_req_drop;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_draw_arbiter.md
Name: sprite_draw_arbiter

Overview:
- Shares the single VGA pixel-write port between up to four sprite draw requesters: background, pet, status bubble and care item (food/ball/broom/pills/first aid).
- On grant, scans a SPR_W x SPR_H sprite from the sprite ROM and emits plot strobes at the requester's origin.
- Skips transparent texels and clips off-screen pixels.
- Sits between the game control FSM's draw_* requests and the VGA adapter.

Parameters:
- X_SCREEN_PIXELS, 160, screen width in pixels.
- Y_SCREEN_PIXELS, 120, screen height in pixels.
- SPR_W, 16, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.
- COLOUR_W, 3, colour bits per pixel.
- TRANSPARENT, 3'b101, texel value that is never plotted.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  per-requester draw request; bit 0 has highest priority.
- req_sprite  in  12  3-bit sprite index per requester; requester i uses bits [3i+2:3i].
- req_x  in  32  8-bit origin x per requester; requester i uses bits [8i+7:8i].
- req_y  in  28  7-bit origin y per requester; requester i uses bits [7i+6:7i].
- grant  out  4  one-hot; high for the whole scan of the granted requester.
- done  out  4  one-cycle completion pulse to the granted requester.
- busy  out  1  high whenever the FSM is not in IDLE.
- rom_addr  out  11  sprite ROM address = sprite*256 + row*16 + col.
- rom_data  in  COLOUR_W  registered ROM output; 1-cycle read latency.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  write strobe to the VGA adapter.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, internal counters 0. Reset mid-scan aborts with no done pulse and no further vga_plot.
- IDLE:
  - When req != 0, select the lowest set index i and latch req_sprite/req_x/req_y for i.
  - Next cycle (G) grant[i]=1 and the FSM enters SCAN.
  - req == 0: stay in IDLE.
- SCAN (cycles G..G+255):
  - One rom_addr per cycle, col fastest. col wraps 15->0 with row++.
  - After (row 15, col 15) go to FLUSH.
- Pixel pipeline:
  - Address issued at cycle t returns rom_data at t+1.
  - vga_x/vga_y/vga_colour/vga_plot are registered and valid at t+2.
  - vga_x = x0+col and vga_y = y0+row, with the sums formed at 9 and 8 bits.
- vga_plot=0 for a pixel if any of these hold:
  - rom_data == TRANSPARENT.
  - 9-bit x sum >= X_SCREEN_PIXELS.
  - 8-bit y sum >= Y_SCREEN_PIXELS.
  - Clipped pixels still consume their cycle.
- FLUSH: 2 cycles (G+256, G+257) to drain the pipeline; the last plot lands at G+257.
- DONE (cycle G+258): grant=0 and done[i]=1 for one cycle, then IDLE at G+259. The earliest next grant is G+260.
- No preemption: req changes during SCAN/FLUSH are ignored. A dropped req does not abort an operation already granted.
- Requesters hold req until grant. A req still high in IDLE after done is re-arbitrated; fixed priority, and starvation is acceptable by design.
- vga_plot is never high in IDLE or DONE. grant and done are never both high.

Test Plan:
- Single request, all-opaque ROM: req=4'b0100, sprite 3, origin (10,20) -> grant=4'b0100 at G; rom_addr=768 at G and 1023 at G+255; vga_plot at (10,20) at G+2 and at (25,35) at G+257; 256 plots; done[2] pulse at G+258.
- Simultaneous request: req=4'b1010 held -> grant[1] first, done[1] at G+258, then grant[3] at G+260; no overlap.
- Clipping: origin (150,110), opaque sprite -> exactly 100 plots, all with x in 150..159 and y in 110..119; done timing unchanged.
- Transparency: ROM returns TRANSPARENT for every odd col -> 128 plots, all at even col offsets; done still at G+258.
- Reset mid-scan: assert reset at G+100 -> next cycle grant=0, vga_plot=0, busy=0; no done pulse; a fresh req is granted normally afterwards.
- Request drop: deassert req at G+5 -> scan completes and done pulses at G+258.
